// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle for the Booth multiply sequencer.
// master drives requests and operands; slave returns status and HI/LO.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             cancel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, cancel, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, cancel, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative signed radix-4 Booth multiplier, one digit per clock, result in HI/LO.
// Define BOOTH_EARLY_TERM_EN to stop after the last significant multiplier digit.
module booth_mul_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = WIDTH / 2
) (
    input logic            clock,
    input logic            clear,
    booth_mul_seq_if.slave bus
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(DIGITS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic              qm1_q, qm1_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [AW-1:0]     m_ext, digit, sum, acc_n;
    logic [WIDTH-1:0]  q_n;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]     last;

`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0]          last_q, last_d;
    logic signed [2*WIDTH+1:0] shifted;
    logic [CW:0]            sh;

    // Index of the final digit that still carries multiplier information.
    function automatic logic [CW-1:0] calc_last(input logic [WIDTH-1:0] a);
        logic [CW-1:0]           r;
        logic signed [WIDTH-1:0] s;
        r = CW'(DIGITS - 1);
        for (int k = DIGITS; k >= 1; k--) begin
            s = $signed(a) >>> (2 * k - 1);
            if (s == '0 || s == '1) r = CW'(k - 1);
        end
        return r;
    endfunction

    assign last    = last_q;
    assign sh      = {CW'(DIGITS - 1) - last_q, 1'b0};
    assign shifted = $signed({acc_n, q_n}) >>> sh;
    assign prod    = shifted[2*WIDTH-1:0];
`else
    assign last = CW'(DIGITS - 1);
    assign prod = {acc_n[WIDTH-1:0], q_n};
`endif

    assign m_ext = {{2{m_q[WIDTH-1]}}, m_q};

    always_comb begin
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: digit = m_ext;
            3'b011:         digit = m_ext << 1;
            3'b100:         digit = -(m_ext << 1);
            3'b101, 3'b110: digit = -m_ext;
            default:        digit = '0;
        endcase
    end

    assign sum   = acc_q + digit;
    assign acc_n = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_n   = {sum[1:0], q_q[WIDTH-1:2]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef BOOTH_EARLY_TERM_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.op_b;
                    acc_d   = '0;
                    q_d     = bus.op_a;
                    qm1_d   = 1'b0;
                    count_d = '0;
`ifdef BOOTH_EARLY_TERM_EN
                    last_d  = calc_last(bus.op_a);
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_n;
                    q_d     = q_n;
                    qm1_d   = q_q[1];
                    count_d = count_q + 1'b1;
                    if (count_q == last) begin
                        hi_d    = prod[2*WIDTH-1:WIDTH];
                        lo_d    = prod[WIDTH-1:0];
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef BOOTH_EARLY_TERM_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef BOOTH_EARLY_TERM_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed, random and control-event scenarios
// checked against an arithmetic product and latency model.
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic clear = 1'b1;
    int   errs = 0;
    int   checks = 0;

    booth_mul_seq_if bus ();

    booth_mul_seq dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int exp_lat(input logic [31:0] a);
`ifdef BOOTH_EARLY_TERM_EN
        longint v;
        longint lim;
        v = longint'($signed(a));
        for (int n = 1; n <= 16; n++) begin
            lim = longint'(1) << (2 * n - 1);
            if (v >= -lim && v < lim) return n + 1;
        end
        return 17;
`else
        return (a === 'x) ? 0 : 17;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] r, output int lat,
                          output int bsy, output bit to);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        lat = 0;
        bsy = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            bus.start = 1'b0;
            if (bus.busy) bsy++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        r = {bus.hi, bus.lo};
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errs++; $display("FAIL reset_done got=%b want=0", bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0) begin
            errs++; $display("FAIL reset_hi got=%h want=0", bus.hi);
        end
        checks++;
        if (bus.lo !== 32'h0) begin
            errs++; $display("FAIL reset_lo got=%h want=0", bus.lo);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [7] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                32'd3, 32'h7FFF_FFFF, 32'h0000_0000};
        logic [31:0] vb [7] = '{32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'd5, 32'h8000_0000, 32'h1234_5678};
        logic [63:0] r;
        int lat, bsy;
        bit to;
        for (int i = 0; i < 7; i++) begin
            do_mul(va[i], vb[i], r, lat, bsy, to);
            checks++;
            if (to) begin
                errs++; $display("FAIL dir_timeout idx=%0d no done in 40 cycles", i);
            end
            checks++;
            if (r !== model(va[i], vb[i])) begin
                errs++; $display("FAIL dir_prod a=%h b=%h got=%h want=%h", va[i], vb[i], r, model(va[i], vb[i]));
            end
            checks++;
            if (lat !== exp_lat(va[i])) begin
                errs++; $display("FAIL dir_latency a=%h got=%0d want=%0d", va[i], lat, exp_lat(va[i]));
            end
            checks++;
            if (bsy !== exp_lat(va[i]) - 1) begin
                errs++; $display("FAIL dir_busy a=%h got=%0d want=%0d", va[i], bsy, exp_lat(va[i]) - 1);
            end
            step();
            checks++;
            if (bus.done !== 1'b0 || {bus.hi, bus.lo} !== model(va[i], vb[i])) begin
                errs++; $display("FAIL dir_after_done done=%b hilo=%h want done=0 hilo=%h", bus.done, {bus.hi, bus.lo}, model(va[i], vb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [63:0] r;
        int lat, bsy;
        bit to;
        for (int i = 0; i < 30; i++) begin
            a = $signed($urandom) >>> $urandom_range(0, 31);
            b = $urandom;
            do_mul(a, b, r, lat, bsy, to);
            checks++;
            if (to || r !== model(a, b)) begin
                errs++; $display("FAIL rnd_prod a=%h b=%h got=%h want=%h to=%b", a, b, r, model(a, b), to);
            end
            checks++;
            if (lat !== exp_lat(a)) begin
                errs++; $display("FAIL rnd_latency a=%h got=%0d want=%0d", a, lat, exp_lat(a));
            end
            step();
        end
    endtask

    task automatic test_start_held();
        logic [31:0] a, b;
        int lat;
        bit to;
        a = {2'b01, 30'($urandom)};
        b = $urandom;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            bus.op_a = $urandom;
            bus.op_b = $urandom;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (to || {bus.hi, bus.lo} !== model(a, b)) begin
            errs++; $display("FAIL held_prod got=%h want=%h to=%b", {bus.hi, bus.lo}, model(a, b), to);
        end
        checks++;
        if (lat !== 17) begin
            errs++; $display("FAIL held_latency got=%0d want=17", lat);
        end
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++; $display("FAIL held_idle busy=%b want=0", bus.busy);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] a, b;
        logic [63:0] prev, r;
        int lat, bsy, dn;
        bit to;
        a = $urandom | 32'd1;
        b = $urandom | 32'd1;
        do_mul(a, b, prev, lat, bsy, to);
        step();
        bus.op_a  = {2'b01, 30'($urandom)};
        bus.op_b  = $urandom;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (bus.busy !== 1'b1) begin
            errs++; $display("FAIL cancel_run8_busy got=%b want=1", bus.busy);
        end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++; $display("FAIL cancel_busy got=%b want=0", bus.busy);
        end
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errs++; $display("FAIL cancel_done got=%0d pulses want=0", dn);
        end
        r = {bus.hi, bus.lo};
        checks++;
        if (r !== model(a, b)) begin
            errs++; $display("FAIL cancel_hilo got=%h want=%h", r, model(a, b));
        end
    endtask

    task automatic test_clear_midrun();
        logic [31:0] a, b;
        logic [63:0] r;
        int lat, bsy;
        bit to;
        do_mul(32'h0001_2345, 32'h0000_0777, r, lat, bsy, to);
        step();
        bus.op_a  = {2'b01, 30'($urandom)};
        bus.op_b  = $urandom;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            errs++; $display("FAIL clear_midrun busy=%b done=%b hi=%h lo=%h want all 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        a = $urandom;
        b = $urandom;
        do_mul(a, b, r, lat, bsy, to);
        checks++;
        if (to || r !== model(a, b)) begin
            errs++; $display("FAIL clear_recover got=%h want=%h to=%b", r, model(a, b), to);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] r;
        int lat, bsy;
        bit to;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        do_mul(a1, b1, r, lat, bsy, to);
        checks++;
        if (to || r !== model(a1, b1)) begin
            errs++; $display("FAIL b2b_first got=%h want=%h", r, model(a1, b1));
        end
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++; $display("FAIL b2b_start_in_done busy=%b want=0", bus.busy);
        end
        do_mul(a2, b2, r, lat, bsy, to);
        checks++;
        if (to || r !== model(a2, b2) || lat !== exp_lat(a2)) begin
            errs++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=%0d", r, lat, model(a2, b2), exp_lat(a2));
        end
        step();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_cancel();
        test_clear_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
